change_dispenser: RTL and testbench

Coin-return unit at the output side of the vending machine. It takes a change request in the machine's 2-bit coin-unit encoding and drives two coin hoppers (5-unit and 10-unit) with timed eject pulses. Each eject is confirmed by a coin sensor before the next one. The block tracks the coin count in each hopper and reports completion, shortfall, or jam back to the vending FSM.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/coin_counter.sv | 47 ++++
 rtl/change_dispenser.sv | 193 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : vend_pkg                                             |
// | Description : Shared coin encodings and dispenser state type       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package vend_pkg;

   // Change amounts in 5-unit steps
   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;
   localparam logic [1:0] COIN_15   = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      EJECT = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      FAULT = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/coin_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : coin_counter                                         |
// | Description : Hopper inventory, saturating add-by-qty / sub-by-1   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module coin_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_qty,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W:0] c_max = {1'b0, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W:0]   w_add;
   logic [CNT_W:0]   w_res;
   logic [CNT_W-1:0] w_next;

   // Add refill first, then take one coin off, then clamp to full scale
   always_comb begin
      w_add = {1'b0, r_cnt} + {1'b0, (i_load ? i_qty : {CNT_W{1'b0}})};
      w_res = w_add;
      if (i_dec && (w_add != '0)) begin
         w_res = w_add - {{CNT_W{1'b0}}, 1'b1};
      end
      w_next = (w_res > c_max) ? c_max[CNT_W-1:0] : w_res[CNT_W-1:0];
   end

   // Inventory register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_next;
      end
   end

   assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : change_dispenser                                     |
// | Description : Greedy coin-return controller for 5/10-unit hoppers  |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module change_dispenser
   import vend_pkg::*;
#(
   parameter int CNT_W        = 4,
   parameter int PULSE_CYCLES = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   input  logic [1:0]       req_amount,
   output logic             req_ready,
   output logic             eject5,
   output logic             eject10,
   input  logic             sense5,
   input  logic             sense10,
   input  logic             load_valid,
   input  logic             load_sel,
   input  logic [CNT_W-1:0] load_qty,
   output logic             done,
   output logic             short,
   output logic [1:0]       paid,
   output logic             jam,
   output logic [CNT_W-1:0] cnt5,
   output logic [CNT_W-1:0] cnt10
);

   localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [PW-1:0] c_pulse_last = PW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] c_tmo_last   = TW'(TIMEOUT - 1);

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_rem, w_rem_nxt;
   logic [1:0]    r_amt, w_amt_nxt;
   logic          r_sel10, w_sel10_nxt;
   logic          r_sensed, w_sensed_nxt;
   logic [PW-1:0] r_pcnt, w_pcnt_nxt;
   logic [TW-1:0] r_tcnt, w_tcnt_nxt;
   logic          r_done, w_done_nxt;
   logic          r_short, w_short_nxt;
   logic [1:0]    r_paid, w_paid_nxt;
   logic          w_confirm;

   logic             w_match, w_other;
   logic [1:0]       w_rem_sub;
   logic [CNT_W:0]   w_bonus;
   logic             w_feasible;

   // The sensor belonging to the hopper currently being driven confirms the
   // coin; the other one can only mean a misrouted coin or a jam
   assign w_match   = r_sel10 ? sense10 : sense5;
   assign w_other   = r_sel10 ? sense5  : sense10;
   assign w_rem_sub = r_rem - (r_sel10 ? COIN_10 : COIN_5);

   // rem is at most 3, so at most one 10 is usable
   assign w_bonus    = (req_amount[1] && (cnt10 != '0)) ? (CNT_W+1)'(2) : '0;
   assign w_feasible = (({1'b0, cnt5} + w_bonus) >= (CNT_W+1)'(req_amount));

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt  = r_state;
      w_rem_nxt    = r_rem;
      w_amt_nxt    = r_amt;
      w_sel10_nxt  = r_sel10;
      w_sensed_nxt = r_sensed;
      w_pcnt_nxt   = r_pcnt;
      w_tcnt_nxt   = r_tcnt;
      w_done_nxt   = 1'b0;
      w_short_nxt  = 1'b0;
      w_paid_nxt   = COIN_NONE;
      w_confirm    = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_rem_nxt = req_amount;
               w_amt_nxt = req_amount;
               if ((req_amount == COIN_NONE) || !w_feasible) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
                  w_short_nxt = !w_feasible;
               end else begin
                  w_state_nxt  = EJECT;
                  w_pcnt_nxt   = '0;
                  w_sensed_nxt = 1'b0;
                  w_sel10_nxt  = req_amount[1] && (cnt10 != '0);
               end
            end
         end
         EJECT, WAIT: begin
            if (w_other) begin
               w_state_nxt = FAULT;
            end else begin
               // A coin is confirmed at most once per pulse
               if (w_match && !(r_state == EJECT && r_sensed)) begin
                  w_confirm    = 1'b1;
                  w_rem_nxt    = w_rem_sub;
                  w_sensed_nxt = 1'b1;
               end
               if ((r_state == WAIT && w_confirm) ||
                   (r_state == EJECT && r_pcnt == c_pulse_last && w_sensed_nxt)) begin
                  if (w_rem_nxt == COIN_NONE) begin
                     w_state_nxt = DONE;
                     w_done_nxt  = 1'b1;
                     w_paid_nxt  = r_amt;
                  end else begin
                     w_state_nxt  = EJECT;
                     w_pcnt_nxt   = '0;
                     w_sensed_nxt = 1'b0;
                     w_sel10_nxt  = w_rem_nxt[1] && (cnt10 != '0);
                  end
               end else if (r_state == EJECT) begin
                  if (r_pcnt == c_pulse_last) begin
                     w_state_nxt = WAIT;
                     w_tcnt_nxt  = '0;
                  end else begin
                     w_pcnt_nxt = r_pcnt + 1'b1;
                  end
               end else if (r_tcnt == c_tmo_last) begin
                  w_state_nxt = FAULT;
               end else begin
                  w_tcnt_nxt = r_tcnt + 1'b1;
               end
            end
         end
         DONE:    w_state_nxt = IDLE;
         FAULT:   w_state_nxt = FAULT;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_rem    <= COIN_NONE;
         r_amt    <= COIN_NONE;
         r_sel10  <= 1'b0;
         r_sensed <= 1'b0;
         r_pcnt   <= '0;
         r_tcnt   <= '0;
         r_done   <= 1'b0;
         r_short  <= 1'b0;
         r_paid   <= COIN_NONE;
      end else begin
         r_state  <= w_state_nxt;
         r_rem    <= w_rem_nxt;
         r_amt    <= w_amt_nxt;
         r_sel10  <= w_sel10_nxt;
         r_sensed <= w_sensed_nxt;
         r_pcnt   <= w_pcnt_nxt;
         r_tcnt   <= w_tcnt_nxt;
         r_done   <= w_done_nxt;
         r_short  <= w_short_nxt;
         r_paid   <= w_paid_nxt;
      end
   end

   coin_counter #(.CNT_W(CNT_W)) u_cnt5 (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (load_valid && !load_sel),
      .i_qty   (load_qty),
      .i_dec   (w_confirm && !r_sel10),
      .o_cnt   (cnt5)
   );

   coin_counter #(.CNT_W(CNT_W)) u_cnt10 (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (load_valid && load_sel),
      .i_qty   (load_qty),
      .i_dec   (w_confirm && r_sel10),
      .o_cnt   (cnt10)
   );

   // Ejects decode straight from reset-cleared state so reset drops them at once
   assign eject5    = (r_state == EJECT) && !r_sel10;
   assign eject10   = (r_state == EJECT) && r_sel10;
   assign req_ready = (r_state == IDLE);
   assign jam       = (r_state == FAULT);
   assign done      = r_done;
   assign short     = r_short;
   assign paid      = r_paid;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_change_dispenser                                  |
// | Description : Directed self-checking bench for change_dispenser    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [1:0] req_amount = 2'b00;
   logic       req_ready;
   logic       eject5, eject10;
   logic       sense5 = 1'b0, sense10 = 1'b0;
   logic       load_valid = 1'b0, load_sel = 1'b0;
   logic [3:0] load_qty = 4'd0;
   logic       done, short, jam;
   logic [1:0] paid;
   logic [3:0] cnt5, cnt10;

   int errors = 0;
   int checks = 0;

   change_dispenser #(.CNT_W(4), .PULSE_CYCLES(4), .TIMEOUT(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_amount (req_amount),
      .req_ready  (req_ready),
      .eject5     (eject5),
      .eject10    (eject10),
      .sense5     (sense5),
      .sense10    (sense10),
      .load_valid (load_valid),
      .load_sel   (load_sel),
      .load_qty   (load_qty),
      .done       (done),
      .short      (short),
      .paid       (paid),
      .jam        (jam),
      .cnt5       (cnt5),
      .cnt10      (cnt10)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req_valid = 1'b0; sense5 = 1'b0; sense10 = 1'b0; load_valid = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
   endtask

   task automatic load(input logic sel, input logic [3:0] qty);
      load_valid = 1'b1; load_sel = sel; load_qty = qty;
      tick();
      load_valid = 1'b0;
   endtask

   // Leaves the bench in the first cycle after the accepting edge
   task automatic request(input logic [1:0] amt);
      req_valid = 1'b1; req_amount = amt;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({req_ready, eject5, eject10, done, short, jam} !== 6'b100000) begin errors++; $display("FAIL reset_flags: got %b expected 100000", {req_ready, eject5, eject10, done, short, jam}); end
      checks++; if ({paid, cnt5, cnt10} !== 10'd0) begin errors++; $display("FAIL reset_data: got paid=%0d cnt5=%0d cnt10=%0d expected all 0", paid, cnt5, cnt10); end
   endtask

   task automatic test_single_five();
      load(1'b0, 4'd3);
      load(1'b1, 4'd2);
      request(2'b01);
      for (int i = 0; i < 4; i++) begin
         checks++; if ({eject5, eject10, req_ready} !== 3'b100) begin errors++; $display("FAIL five_pulse%0d: got e5/e10/rdy=%b expected 100", i, {eject5, eject10, req_ready}); end
         tick();
      end
      checks++; if (eject5 !== 1'b0) begin errors++; $display("FAIL five_release: got eject5=%b expected 0", eject5); end
      tick();
      sense5 = 1'b1; tick(); sense5 = 1'b0;
      checks++; if ({done, short, paid, cnt5} !== {1'b1, 1'b0, 2'b01, 4'd2}) begin errors++; $display("FAIL five_done: got done=%b short=%b paid=%b cnt5=%0d expected 1 0 01 2", done, short, paid, cnt5); end
      tick();
      checks++; if ({done, req_ready} !== 2'b01) begin errors++; $display("FAIL five_idle: got done/rdy=%b expected 01", {done, req_ready}); end
   endtask

   task automatic test_fifteen();
      request(2'b11);
      for (int i = 0; i < 4; i++) begin
         checks++; if ({eject5, eject10} !== 2'b01) begin errors++; $display("FAIL fifteen_ten%0d: got e5/e10=%b expected 01", i, {eject5, eject10}); end
         tick();
      end
      sense10 = 1'b1; tick(); sense10 = 1'b0;
      checks++; if ({eject5, eject10, cnt10} !== {2'b10, 4'd1}) begin errors++; $display("FAIL fifteen_switch: got e5/e10=%b cnt10=%0d expected 10 1", {eject5, eject10}, cnt10); end
      for (int i = 0; i < 4; i++) tick();
      sense5 = 1'b1; tick(); sense5 = 1'b0;
      checks++; if ({done, paid, cnt5, cnt10} !== {1'b1, 2'b11, 4'd1, 4'd1}) begin errors++; $display("FAIL fifteen_done: got done=%b paid=%b cnt5=%0d cnt10=%0d expected 1 11 1 1", done, paid, cnt5, cnt10); end
   endtask

   task automatic test_short_and_zero();
      do_reset();
      load(1'b0, 4'd1);
      request(2'b10);
      checks++; if ({done, short, paid, eject5, eject10} !== 6'b110000) begin errors++; $display("FAIL short_done: got done/short/paid/e5/e10=%b expected 110000", {done, short, paid, eject5, eject10}); end
      tick();
      checks++; if ({req_ready, done, cnt5, cnt10} !== {2'b10, 4'd1, 4'd0}) begin errors++; $display("FAIL short_after: got rdy/done=%b cnt5=%0d cnt10=%0d expected 10 1 0", {req_ready, done}, cnt5, cnt10); end
      request(2'b00);
      checks++; if ({done, short, paid, eject5} !== 5'b10000) begin errors++; $display("FAIL zero_done: got done/short/paid/e5=%b expected 10000", {done, short, paid, eject5}); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      load(1'b0, 4'd3);
      request(2'b10);
      sense5 = 1'b1; tick(); sense5 = 1'b0;
      checks++; if ({eject5, cnt5} !== {1'b1, 4'd2}) begin errors++; $display("FAIL early_sense: got eject5=%b cnt5=%0d expected 1 2", eject5, cnt5); end
      tick(); tick(); tick();
      checks++; if (eject5 !== 1'b1) begin errors++; $display("FAIL skip_wait: got eject5=%b expected 1", eject5); end
      for (int i = 0; i < 4; i++) tick();
      checks++; if (eject5 !== 1'b0) begin errors++; $display("FAIL second_wait: got eject5=%b expected 0", eject5); end
      sense5 = 1'b1; tick(); sense5 = 1'b0;
      checks++; if ({done, paid, cnt5} !== {1'b1, 2'b10, 4'd1}) begin errors++; $display("FAIL b2b_done: got done=%b paid=%b cnt5=%0d expected 1 10 1", done, paid, cnt5); end
   endtask

   task automatic test_timeout();
      do_reset();
      load(1'b0, 4'd1);
      request(2'b01);
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 15; i++) tick();
      checks++; if (jam !== 1'b0) begin errors++; $display("FAIL tmo_early: got jam=%b expected 0", jam); end
      tick();
      checks++; if ({jam, req_ready, eject5, eject10} !== 4'b1000) begin errors++; $display("FAIL tmo_fault: got jam/rdy/e5/e10=%b expected 1000", {jam, req_ready, eject5, eject10}); end
      load(1'b1, 4'd5);
      checks++; if ({cnt10, jam} !== {4'd5, 1'b1}) begin errors++; $display("FAIL fault_refill: got cnt10=%0d jam=%b expected 5 1", cnt10, jam); end
      reset_n = 1'b0; #1;
      checks++; if ({jam, req_ready, cnt10} !== {2'b01, 4'd0}) begin errors++; $display("FAIL fault_reset: got jam/rdy=%b cnt10=%0d expected 01 0", {jam, req_ready}, cnt10); end
      tick(); reset_n = 1'b1;
   endtask

   task automatic test_wrong_sensor();
      do_reset();
      load(1'b0, 4'd1);
      request(2'b01);
      sense10 = 1'b1; tick(); sense10 = 1'b0;
      checks++; if ({jam, eject5, cnt5} !== {2'b10, 4'd1}) begin errors++; $display("FAIL wrong_sense: got jam/e5=%b cnt5=%0d expected 10 1", {jam, eject5}, cnt5); end
   endtask

   task automatic test_async_reset();
      do_reset();
      load(1'b0, 4'd1);
      request(2'b01);
      checks++; if (eject5 !== 1'b1) begin errors++; $display("FAIL arst_pre: got eject5=%b expected 1", eject5); end
      reset_n = 1'b0; #1;
      checks++; if ({eject5, cnt5} !== {1'b0, 4'd0}) begin errors++; $display("FAIL arst_drop: got eject5=%b cnt5=%0d expected 0 0", eject5, cnt5); end
      tick(); reset_n = 1'b1;
   endtask

   task automatic test_saturation();
      do_reset();
      load(1'b0, 4'd15);
      request(2'b01);
      sense5 = 1'b1; load_valid = 1'b1; load_sel = 1'b0; load_qty = 4'd3;
      tick();
      sense5 = 1'b0; load_valid = 1'b0;
      checks++; if (cnt5 !== 4'd15) begin errors++; $display("FAIL sat_cnt5: got %0d expected 15", cnt5); end
      tick(); tick(); tick();
      checks++; if ({done, paid} !== 3'b101) begin errors++; $display("FAIL sat_done: got done/paid=%b expected 101", {done, paid}); end
      do_reset();
      load(1'b0, 4'd2);
      request(2'b01);
      sense5 = 1'b1; load_valid = 1'b1; load_sel = 1'b0; load_qty = 4'd1;
      tick();
      sense5 = 1'b0; load_valid = 1'b0;
      checks++; if (cnt5 !== 4'd2) begin errors++; $display("FAIL load_dec: got %0d expected 2", cnt5); end
   endtask

   initial begin
      test_reset();
      test_single_five();
      test_fifteen();
      test_short_and_zero();
      test_back_to_back();
      test_timeout();
      test_wrong_sensor();
      test_async_reset();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
